// File: rtl/ext_interrupt_ctrl_if.sv
// Core-facing bus of the external interrupt controller: the IO_* register port
// and the EIC_IntReq/EIC_IntId/EIC_IntAck handshake.
interface ext_interrupt_ctrl_if;
    logic        IO_EnR;
    logic        IO_EnW;
    logic [29:0] IO_Address;
    logic [31:0] IO_DataW;
    logic [31:0] IO_DataR;
    logic        EIC_IntReq;
    logic        EIC_IntId;
    logic        EIC_IntAck;

    modport master (
        output IO_EnR, IO_EnW, IO_Address, IO_DataW, EIC_IntAck,
        input  IO_DataR, EIC_IntReq, EIC_IntId
    );

    modport slave (
        input  IO_EnR, IO_EnW, IO_Address, IO_DataW, EIC_IntAck,
        output IO_DataR, EIC_IntReq, EIC_IntId
    );
endinterface

// File: rtl/ext_interrupt_ctrl.sv
// External interrupt controller: synchronizes two IRQ lines into pending bits and
// hands the highest-priority unmasked source to the core with a held request.
module ext_interrupt_ctrl #(
    parameter logic [29:0] BASE_ADDR   = 30'h0000_0040,
    parameter int          SYNC_STAGES = 2,
    parameter int          GAP_CYCLES  = 1
) (
    input  logic                  Sys_Clock,
    input  logic                  Sys_Reset,
    input  logic [1:0]            Irq_In,
    ext_interrupt_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} eicState_t;

    logic [1:0]  syncPipe [SYNC_STAGES];
    logic [1:0]  syncVal, syncD, edgeSeen;
    logic [1:0]  pendReg, pendNext, maskReg, modeReg, eligible, w1c, ackClr;
    logic [31:0] dataRReg, readValue;
    logic [29:0] addrOffset;
    logic        regHit, readHit, writeHit;
    eicState_t   state, stateNext;
    logic        reqReg, reqNext, idReg, idNext, lastId, lastIdNext;
    logic [2:0]  gapCnt, gapNext;
    logic        unusedDataW;

    assign syncVal     = syncPipe[SYNC_STAGES-1];
    assign edgeSeen    = syncVal & ~syncD;
    assign eligible    = pendReg & ~maskReg;
    assign unusedDataW = ^bus.IO_DataW[31:2];

    assign bus.IO_DataR   = dataRReg;
    assign bus.EIC_IntReq = reqReg;
    assign bus.EIC_IntId  = idReg;

    // Address decode, read mux and W1C mask for the four-word register window.
    always_comb begin
        addrOffset = bus.IO_Address - BASE_ADDR;
        regHit     = (bus.IO_Address >= BASE_ADDR) && (addrOffset[29:2] == 28'd0);
        readHit    = bus.IO_EnR && regHit;
        writeHit   = bus.IO_EnW && regHit;
        readValue  = 32'd0;
        case (addrOffset[1:0])
            2'd0:    readValue = {30'd0, pendReg};
            2'd1:    readValue = {30'd0, maskReg};
            2'd2:    readValue = {30'd0, modeReg};
            2'd3:    readValue = {28'd0, (state == GAP), lastId, idReg, reqReg};
            default: readValue = 32'd0;
        endcase
        if (writeHit && (addrOffset[1:0] == 2'd0)) begin
            w1c = bus.IO_DataW[1:0];
        end else begin
            w1c = 2'b00;
        end
    end

    // Request FSM: arbitrate in IDLE, hold in REQ until ack, idle out the gap.
    always_comb begin
        stateNext  = state;
        reqNext    = reqReg;
        idNext     = idReg;
        lastIdNext = lastId;
        gapNext    = gapCnt;
        ackClr     = 2'b00;
        case (state)
            IDLE: begin
                if (eligible != 2'b00) begin
                    stateNext = REQ;
                    reqNext   = 1'b1;
                    idNext    = ~eligible[0];
                end else begin
                    stateNext = IDLE;
                end
            end
            REQ: begin
                if (bus.EIC_IntAck) begin
                    stateNext  = GAP;
                    reqNext    = 1'b0;
                    lastIdNext = idReg;
                    gapNext    = 3'd0;
                    ackClr     = idReg ? {modeReg[1], 1'b0} : {1'b0, modeReg[0]};
                end else begin
                    stateNext = REQ;
                end
            end
            GAP: begin
                if (gapCnt == 3'(GAP_CYCLES - 1)) begin
                    stateNext = IDLE;
                end else begin
                    gapNext = gapCnt + 3'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                reqNext   = 1'b0;
            end
        endcase
    end

    // Pending update: level bits follow the input, edge bits latch; a new edge beats any clear.
    always_comb begin
        pendNext = pendReg;
        for (int i = 0; i < 2; i++) begin
            if (modeReg[i]) begin
                pendNext[i] = (pendReg[i] & ~w1c[i] & ~ackClr[i]) | edgeSeen[i];
            end else begin
                pendNext[i] = syncVal[i];
            end
        end
    end

    // Input synchronizer and edge-detect flop.
    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) syncPipe[k] <= 2'b00;
            syncD <= 2'b00;
        end else begin
            syncPipe[0] <= Irq_In;
            for (int k = 1; k < SYNC_STAGES; k++) syncPipe[k] <= syncPipe[k-1];
            syncD <= syncVal;
        end
    end

    // Register file and registered read data.
    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            pendReg  <= 2'b00;
            maskReg  <= 2'b11;
            modeReg  <= 2'b00;
            dataRReg <= 32'd0;
        end else begin
            pendReg <= pendNext;
            if (writeHit && (addrOffset[1:0] == 2'd1)) maskReg <= bus.IO_DataW[1:0];
            if (writeHit && (addrOffset[1:0] == 2'd2)) modeReg <= bus.IO_DataW[1:0];
            if (readHit) dataRReg <= readValue;
        end
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            state  <= IDLE;
            reqReg <= 1'b0;
            idReg  <= 1'b0;
            lastId <= 1'b0;
            gapCnt <= 3'd0;
        end else begin
            state  <= stateNext;
            reqReg <= reqNext;
            idReg  <= idNext;
            lastId <= lastIdNext;
            gapCnt <= gapNext;
        end
    end

endmodule

// File: tb/tb_ext_interrupt_ctrl.sv
// Directed self-checking bench for ext_interrupt_ctrl (BASE_ADDR=0x40, 2 sync stages, 1 gap cycle).
module tb_ext_interrupt_ctrl;

    localparam logic [29:0] BASE = 30'h0000_0040;
    localparam int SYNC = 2;
    localparam int GAPC = 1;

    logic       Sys_Clock = 1'b0;
    logic       Sys_Reset;
    logic [1:0] Irq_In;
    int vectors = 0;
    int miscompares = 0;
    int waited;
    int highSeen;
    logic [31:0] rd;

    ext_interrupt_ctrl_if bus ();

    ext_interrupt_ctrl #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC), .GAP_CYCLES(GAPC)) dut (
        .Sys_Clock (Sys_Clock),
        .Sys_Reset (Sys_Reset),
        .Irq_In    (Irq_In),
        .bus       (bus)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    task automatic tick();
        @(posedge Sys_Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ioWrite(input logic [29:0] addr, input logic [31:0] data);
        bus.IO_EnW = 1'b1; bus.IO_Address = addr; bus.IO_DataW = data;
        tick();
        bus.IO_EnW = 1'b0;
    endtask

    task automatic ioRead(input logic [29:0] addr, output logic [31:0] data);
        bus.IO_EnR = 1'b1; bus.IO_Address = addr;
        tick();
        bus.IO_EnR = 1'b0;
        data = bus.IO_DataR;
    endtask

    task automatic ackPulse();
        bus.EIC_IntAck = 1'b1;
        tick();
        bus.EIC_IntAck = 1'b0;
    endtask

    task automatic waitReq(input int budget, output int n);
        n = 0;
        while (!bus.EIC_IntReq && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        Sys_Reset = 1'b1; Irq_In = 2'b00;
        bus.IO_EnR = 1'b0; bus.IO_EnW = 1'b0; bus.IO_Address = 30'd0;
        bus.IO_DataW = 32'd0; bus.EIC_IntAck = 1'b0;
        tick(); tick();
        Sys_Reset = 1'b0;

        // Reset state
        check("rst_datar", bus.IO_DataR, 32'd0);
        check("rst_req", 32'(bus.EIC_IntReq), 32'd0);
        check("rst_id", 32'(bus.EIC_IntId), 32'd0);
        ioRead(BASE + 30'd1, rd); check("rst_mask", rd, 32'h3);
        ioRead(BASE + 30'd0, rd); check("rst_pend", rd, 32'h0);
        ioRead(BASE + 30'd2, rd); check("rst_mode", rd, 32'h0);

        // 1: edge mode, 3-cycle pulse on IRQ1
        ioWrite(BASE + 30'd1, 32'h0);
        ioWrite(BASE + 30'd2, 32'h3);
        Irq_In = 2'b10; waited = 0;
        while (!bus.EIC_IntReq && waited < SYNC + 2) begin
            tick();
            waited++;
            if (waited == 3) Irq_In = 2'b00;
        end
        Irq_In = 2'b00;
        check("t1_req", 32'(bus.EIC_IntReq), 32'd1);
        check("t1_id", 32'(bus.EIC_IntId), 32'd1);
        ackPulse();
        check("t1_req_after_ack", 32'(bus.EIC_IntReq), 32'd0);
        ioRead(BASE + 30'd0, rd); check("t1_pend", rd, 32'h0);
        ioRead(BASE + 30'd3, rd);
        check("t1_lastid", 32'(rd[2]), 32'd1);
        check("t1_status_req", 32'(rd[0]), 32'd0);

        // 2: both rise together, id 0 first, then id 1 after the gap
        Irq_In = 2'b11;
        waitReq(6, waited);
        check("t2_req0", 32'(bus.EIC_IntReq), 32'd1);
        check("t2_id0", 32'(bus.EIC_IntId), 32'd0);
        ackPulse();
        check("t2_drop", 32'(bus.EIC_IntReq), 32'd0);
        waitReq(6, waited);
        check("t2_gap_len", 32'(waited >= GAPC), 32'd1);
        check("t2_req1", 32'(bus.EIC_IntReq), 32'd1);
        check("t2_id1", 32'(bus.EIC_IntId), 32'd1);

        // 3: higher-priority arrival does not retract the held request
        Irq_In = 2'b10;
        tick(); tick(); tick();
        Irq_In = 2'b11;
        tick(); tick(); tick(); tick();
        check("t3_held_req", 32'(bus.EIC_IntReq), 32'd1);
        check("t3_held_id", 32'(bus.EIC_IntId), 32'd1);
        ackPulse();
        check("t3_drop", 32'(bus.EIC_IntReq), 32'd0);
        waitReq(6, waited);
        check("t3_req0", 32'(bus.EIC_IntReq), 32'd1);
        check("t3_id0", 32'(bus.EIC_IntId), 32'd0);
        ackPulse();
        Irq_In = 2'b00;
        tick(); tick(); tick(); tick();
        check("t3_idle", 32'(bus.EIC_IntReq), 32'd0);

        // 4: level mode on bit 0 re-requests while held high
        ioWrite(BASE + 30'd2, 32'h2);
        Irq_In = 2'b01;
        waitReq(6, waited);
        check("t4_req", 32'(bus.EIC_IntReq), 32'd1);
        check("t4_id", 32'(bus.EIC_IntId), 32'd0);
        ackPulse();
        check("t4_drop", 32'(bus.EIC_IntReq), 32'd0);
        waitReq(6, waited);
        check("t4_rereq", 32'(bus.EIC_IntReq), 32'd1);
        check("t4_reid", 32'(bus.EIC_IntId), 32'd0);
        Irq_In = 2'b00;
        for (int i = 0; i < SYNC + 1; i++) tick();
        ioRead(BASE + 30'd0, rd); check("t4_pend_low", rd, 32'h0);
        check("t4_still_held", 32'(bus.EIC_IntReq), 32'd1);
        ackPulse();
        highSeen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.EIC_IntReq) highSeen++;
            tick();
        end
        check("t4_no_more_req", 32'(highSeen), 32'd0);

        // 5: mask write keeps only [1:0]; out-of-range reads leave IO_DataR alone
        ioWrite(BASE + 30'd1, 32'hFFFF_FFFE);
        ioRead(BASE + 30'd1, rd); check("t5_mask", rd, 32'h2);
        ioRead(BASE + 30'd4, rd); check("t5_miss_hi", rd, 32'h2);
        ioRead(BASE - 30'd1, rd); check("t5_miss_lo", rd, 32'h2);
        ioRead(BASE + 30'd2, rd); check("t5_mode", rd, 32'h2);

        // 6: reset while requesting
        ioWrite(BASE + 30'd1, 32'h0);
        ioWrite(BASE + 30'd2, 32'h3);
        Irq_In = 2'b10;
        waitReq(6, waited);
        check("t6_req", 32'(bus.EIC_IntReq), 32'd1);
        Sys_Reset = 1'b1;
        tick();
        Sys_Reset = 1'b0;
        check("t6_rst_req", 32'(bus.EIC_IntReq), 32'd0);
        check("t6_rst_datar", bus.IO_DataR, 32'd0);
        ioRead(BASE + 30'd1, rd); check("t6_mask", rd, 32'h3);
        ioRead(BASE + 30'd0, rd); check("t6_pend", rd, 32'h0);
        highSeen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.EIC_IntReq) highSeen++;
            tick();
        end
        check("t6_masked_quiet", 32'(highSeen), 32'd0);
        ioWrite(BASE + 30'd1, 32'h0);
        waitReq(6, waited);
        check("t6_unmask_req", 32'(bus.EIC_IntReq), 32'd1);
        check("t6_unmask_id", 32'(bus.EIC_IntId), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
